mdio_phy_responder: RTL
=======================

# mdio_phy_responder

PHY-side Clause 22 MDIO management responder: the far end of the MAC's bit-banged MDC/MDIO master. It oversamples MDC/MDIO on the system clock, decodes read and write frames addressed to its PHY address, and serves a small PHY register file. It drives MDIO only during read turnaround and read data. It sits in the Ethernet PHY model used for simulation and loopback FPGA builds, wired directly to the MAC's `o_edutmdc`, `o_edutmdio` and `oe_edutmdio` pins.

## Interface
- `PHY_ADDR`, default 5'd1: PHY address this instance answers.
- `PHYID1`, default 16'h0007: value of register 2.
- `PHYID2`, default 16'hC0F1: value of register 3.
- `PRE_LEN`, default 32: number of consecutive 1s required as preamble.
- `msoc_clk` in 1: system clock; the only clock.
- `rstn` in 1: asynchronous, active-low reset.
- `i_mdc` in 1: MDC from the MAC; asynchronous to `msoc_clk`.
- `i_mdio` in 1: resolved MDIO line value.
- `o_mdio` out 1: MDIO drive value.
- `oe_mdio` out 1: MDIO drive enable.
- `i_link` in 1: link status; reflected in BMSR[2].
- `loopback` out 1: BMCR[14].
- `power_down` out 1: BMCR[11].
- `phy_soft_rst` out 1: one-cycle pulse when BMCR[15] is written as 1.
- `an_restart` out 1: one-cycle pulse when BMCR[9] is written as 1.

## Operation
- Both `i_mdc` and `i_mdio` pass through two-flop synchronizers.
- `rise` = synced MDC high and its delayed copy low. All protocol activity happens only in cycles where `rise` is high, using the synced MDIO value.
- State machine `IDLE`, `ST`, `OP`, `PHYAD`, `REGAD`, `TA`, `DATA`:
  - `IDLE`: 6-bit preamble counter counts sampled 1s, saturating at `PRE_LEN`. A 0 with count < `PRE_LEN` clears the counter. A 0 with count ≥ `PRE_LEN` (first ST bit) goes to `ST`.
  - `ST`: sampled 1 goes to `OP`; sampled 0 goes to `IDLE` with counter cleared.
  - `OP`: 2 bits, MSB first. 2'b10 is read, 2'b01 is write. 00 or 11 aborts to `IDLE`.
  - `PHYAD`: 5 bits, then `REGAD`: 5 bits, MSB first. Set `hit` = (PHYAD == `PHY_ADDR`).
  - `TA`: 2 bit times.
    - Read with `hit`: `oe_mdio` stays 0 for TA bit 1. At the rise ending TA bit 1, drive `o_mdio`=0 with `oe_mdio`=1.
    - Write: TA bit values are ignored.
  - `DATA`: 16 bits, MSB first.
    - Read with `hit`: at each later rise, shift out the next bit, D15 first. At the rise sampling D0, `oe_mdio`=0.
    - Write: shift in the 16 sampled bits. Commit on the rise sampling D0, only if `hit`.
  - After `DATA`, return to `IDLE` with the counter cleared. A new preamble is required for every frame.
  - Without `hit`, the block stays passive (`oe_mdio`=0) through `DATA`.
- Register file:
  - 0 BMCR, rw. Reset value 16'h3100. Implemented bits are 14, 13, 12, 11, 8; all others read 0.
    - Bit 15 is self-clearing: it pulses `phy_soft_rst` and restores every rw register to its default.
    - Bit 9 is self-clearing: it pulses `an_restart`.
  - 1 BMSR, ro: 16'h7809 | (`i_link`<<2).
  - 2 and 3, ro: `PHYID1` and `PHYID2`.
  - 4 ANAR, rw, default 16'h01E1.
  - 31 scratch, rw, default 16'h0000.
  - All other addresses read 16'h0000; writes to them are ignored.
- The read value is latched at the rise that samples REGAD bit 0.
- Reset values of outputs: `o_mdio`=0, `oe_mdio`=0, `loopback`=0, `power_down`=0, `phy_soft_rst`=0, `an_restart`=0. State is `IDLE`, counter 0, registers at defaults.
- Reset asserted mid-frame forces all of the above immediately, regardless of the clock.

## Timing
- Latency from an MDC pin rising edge to the change on `o_mdio`/`oe_mdio`: 3 `msoc_clk` edges (2 sync + 1 output register). Outputs are registered.
- MDC high and low phases must each be ≥ 3 `msoc_clk` periods. Behaviour with faster MDC is undefined.
- Write commit, `phy_soft_rst` and `an_restart` take effect in the cycle after the rise sampling D0. Pulses last exactly 1 cycle.
- A BMCR write with bits 15 and 14 both set: defaults win, so `loopback`=0.
- MDC falling edges are ignored. MDIO is sampled only on `rise`.

## Structure
- `mdio_pkg`:
  - State enum `mdio_state_t`.
  - Opcode constants `MDIO_OP_RD`=2'b10 and `MDIO_OP_WR`=2'b01.
  - Register address constants `REG_BMCR`, `REG_BMSR`, `REG_PHYID1`, `REG_PHYID2`, `REG_ANAR`, `REG_SCRATCH`.
  - Default values `BMCR_DEF`, `ANAR_DEF`, `BMSR_BASE`.
- Sub-module `mdio_sync_edge`: 2-flop synchronizer plus rise detect, instantiated for MDC. An MDIO instance ignores the edge output.
- Frame FSM, shift registers and register file live in the top module.

## Test plan
- Preamble of 32 ones, read of PHYAD 1, REGAD 2 → `oe_mdio` 0 during TA bit 1, then `o_mdio` 0, then 16'h0007 MSB first; `oe_mdio` drops after D0.
- Write of 16'h05E1 to REGAD 4, then read of REGAD 4 → returns 16'h05E1. Read of REGAD 7 → returns 16'h0000.
- Write of 16'h8000 to BMCR → `phy_soft_rst` high for exactly 1 cycle, ANAR back to 16'h01E1, BMCR reads 16'h3100. Write of 16'h4000 → `loopback`=1.
- Preamble of only 31 ones followed by a write frame → ignored, no register change. Read with OP 2'b11 → `oe_mdio` never asserts.
- Read of PHYAD 2 → `oe_mdio` stays 0 for the whole frame. The immediately following valid read of BMSR with `i_link`=1 → returns 16'h780D.
- `rstn` asserted at read data bit 8 → `oe_mdio`=0 without a clock edge. After release, the next valid read returns defaults.

Source files
------------

// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared types and constants for the Clause 22 MDIO PHY responder
// Contents: frame state enum, opcode values, register addresses, register defaults.
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA,
    DATA
  } mdio_state_t;

  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;

  localparam logic [4:0] REG_BMCR    = 5'd0;
  localparam logic [4:0] REG_BMSR    = 5'd1;
  localparam logic [4:0] REG_PHYID1  = 5'd2;
  localparam logic [4:0] REG_PHYID2  = 5'd3;
  localparam logic [4:0] REG_ANAR    = 5'd4;
  localparam logic [4:0] REG_SCRATCH = 5'd31;

  localparam logic [15:0] BMCR_DEF     = 16'h3100;
  localparam logic [15:0] ANAR_DEF     = 16'h01E1;
  localparam logic [15:0] BMSR_BASE    = 16'h7809;
  // Storage bits of BMCR: loopback(14), speed(13), AN enable(12), power down(11), duplex(8).
  localparam logic [15:0] BMCR_RW_MASK = 16'h7900;

endpackage

// File: rtl/mdio_sync_edge.sv
// rtl/mdio_sync_edge.sv - two-flop synchronizer with rising-edge detect
// Ports: clk/rstn system clock and async active-low reset, d asynchronous input,
//        q synchronized level, rise one-cycle strobe when q goes 0->1.
module mdio_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= d;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign q    = sync;
  assign rise = sync & ~sync_d;

endmodule

// File: rtl/mdio_phy_responder.sv
// rtl/mdio_phy_responder.sv - PHY-side Clause 22 MDIO responder with a small register file
// Ports: msoc_clk system clock, rstn async active-low reset,
//        i_mdc/i_mdio MDC and resolved MDIO line from the MAC side,
//        o_mdio/oe_mdio registered MDIO drive value and enable,
//        i_link link status (BMSR[2]), loopback/power_down BMCR bits,
//        phy_soft_rst/an_restart one-cycle pulses from self-clearing BMCR bits.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHYID1   = 16'h0007,
  parameter logic [15:0] PHYID2   = 16'hC0F1,
  parameter int          PRE_LEN  = 32
) (
  input  logic msoc_clk,
  input  logic rstn,
  input  logic i_mdc,
  input  logic i_mdio,
  output logic o_mdio,
  output logic oe_mdio,
  input  logic i_link,
  output logic loopback,
  output logic power_down,
  output logic phy_soft_rst,
  output logic an_restart
);

  localparam logic [5:0] PRE_MAX = 6'(PRE_LEN);

  logic mdc_rise;
  logic mdc_lvl_unused;
  logic mdio_s;
  logic mdio_rise_unused;

  mdio_sync_edge u_sync_mdc (
    .clk  (msoc_clk),
    .rstn (rstn),
    .d    (i_mdc),
    .q    (mdc_lvl_unused),
    .rise (mdc_rise)
  );

  mdio_sync_edge u_sync_mdio (
    .clk  (msoc_clk),
    .rstn (rstn),
    .d    (i_mdio),
    .q    (mdio_s),
    .rise (mdio_rise_unused)
  );

  mdio_state_t state, state_nxt;
  logic [5:0]  pre_cnt, pre_cnt_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [1:0]  op, op_nxt;
  logic [4:0]  phyad, phyad_nxt;
  logic [4:0]  regad, regad_nxt;
  logic        hit, hit_nxt;
  logic [15:0] data_sh, data_nxt;
  logic        o_nxt, oe_nxt;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] rd_val;
  logic [1:0]  op_bits;
  logic        drive;

  logic [15:0] bmcr, anar, scratch;

  assign op_bits = {op[0], mdio_s};
  assign drive   = (op == MDIO_OP_RD) && hit;
  // The last data bit arrives on the committing rise itself.
  assign wr_data = {data_sh[14:0], mdio_s};

  // Read mux indexed by the complete register address as it becomes known
  // on the rise sampling REGAD bit 0.
  always_comb begin
    rd_val = 16'h0000;
    case ({regad[3:0], mdio_s})
      REG_BMCR:    rd_val = bmcr;
      REG_BMSR:    rd_val = BMSR_BASE | {13'd0, i_link, 2'd0};
      REG_PHYID1:  rd_val = PHYID1;
      REG_PHYID2:  rd_val = PHYID2;
      REG_ANAR:    rd_val = anar;
      REG_SCRATCH: rd_val = scratch;
      default:     rd_val = 16'h0000;
    endcase
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      pre_cnt <= 6'd0;
      bit_cnt <= 4'd0;
      op      <= 2'b00;
      phyad   <= 5'd0;
      regad   <= 5'd0;
      hit     <= 1'b0;
      data_sh <= 16'h0000;
      o_mdio  <= 1'b0;
      oe_mdio <= 1'b0;
    end else begin
      state   <= state_nxt;
      pre_cnt <= pre_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      op      <= op_nxt;
      phyad   <= phyad_nxt;
      regad   <= regad_nxt;
      hit     <= hit_nxt;
      data_sh <= data_nxt;
      o_mdio  <= o_nxt;
      oe_mdio <= oe_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pre_cnt_nxt = pre_cnt;
    bit_cnt_nxt = bit_cnt;
    op_nxt      = op;
    phyad_nxt   = phyad;
    regad_nxt   = regad;
    hit_nxt     = hit;
    data_nxt    = data_sh;
    o_nxt       = o_mdio;
    oe_nxt      = oe_mdio;
    wr_en       = 1'b0;

    if (mdc_rise) begin
      case (state)
        IDLE: begin
          if (mdio_s) begin
            if (pre_cnt < PRE_MAX) pre_cnt_nxt = pre_cnt + 6'd1;
          end else if (pre_cnt >= PRE_MAX) begin
            // Counter is cleared on frame entry so every exit path back to
            // IDLE already finds it at zero.
            state_nxt   = ST;
            pre_cnt_nxt = 6'd0;
          end else begin
            pre_cnt_nxt = 6'd0;
          end
        end

        ST: begin
          bit_cnt_nxt = 4'd0;
          state_nxt   = mdio_s ? OP : IDLE;
        end

        OP: begin
          op_nxt = op_bits;
          if (bit_cnt == 4'd1) begin
            bit_cnt_nxt = 4'd0;
            state_nxt   = (op_bits == MDIO_OP_RD || op_bits == MDIO_OP_WR) ? PHYAD : IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end

        PHYAD: begin
          phyad_nxt = {phyad[3:0], mdio_s};
          if (bit_cnt == 4'd4) begin
            bit_cnt_nxt = 4'd0;
            state_nxt   = REGAD;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end

        REGAD: begin
          regad_nxt = {regad[3:0], mdio_s};
          if (bit_cnt == 4'd4) begin
            bit_cnt_nxt = 4'd0;
            hit_nxt     = (phyad == PHY_ADDR);
            data_nxt    = rd_val;
            state_nxt   = TA;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end

        TA: begin
          if (bit_cnt == 4'd0) begin
            // First TA bit is left floating; take the line for the second.
            if (drive) begin
              o_nxt  = 1'b0;
              oe_nxt = 1'b1;
            end
            bit_cnt_nxt = 4'd1;
          end else begin
            if (drive) begin
              o_nxt    = data_sh[15];
              data_nxt = {data_sh[14:0], 1'b0};
            end
            bit_cnt_nxt = 4'd0;
            state_nxt   = DATA;
          end
        end

        DATA: begin
          if (op == MDIO_OP_RD) begin
            if (bit_cnt == 4'd15) begin
              o_nxt  = 1'b0;
              oe_nxt = 1'b0;
            end else if (drive) begin
              o_nxt    = data_sh[15];
              data_nxt = {data_sh[14:0], 1'b0};
            end
          end else begin
            data_nxt = wr_data;
            if (bit_cnt == 4'd15) wr_en = hit;
          end
          if (bit_cnt == 4'd15) begin
            bit_cnt_nxt = 4'd0;
            state_nxt   = IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end

        default: begin
          state_nxt   = IDLE;
          pre_cnt_nxt = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      bmcr         <= BMCR_DEF;
      anar         <= ANAR_DEF;
      scratch      <= 16'h0000;
      phy_soft_rst <= 1'b0;
      an_restart   <= 1'b0;
    end else begin
      phy_soft_rst <= 1'b0;
      an_restart   <= 1'b0;
      if (wr_en) begin
        case (regad)
          REG_BMCR: begin
            // Soft reset takes precedence over the other written bits.
            if (wr_data[15]) begin
              bmcr         <= BMCR_DEF;
              anar         <= ANAR_DEF;
              scratch      <= 16'h0000;
              phy_soft_rst <= 1'b1;
            end else begin
              bmcr <= wr_data & BMCR_RW_MASK;
            end
            an_restart <= wr_data[9];
          end
          REG_ANAR:    anar    <= wr_data;
          REG_SCRATCH: scratch <= wr_data;
          default: ;
        endcase
      end
    end
  end

  assign loopback   = bmcr[14];
  assign power_down = bmcr[11];

endmodule
